// File: rtl/xcarry_pkg.sv
// Shared constants, widths and FSM encoding for the xcarry column-carry reducer.
// Build option: define XCARRY_FOLD_EN to enable the mod 2^255-19 fold step.
// Without it the final carry leaves as a 6th output beat and no fold happens.
package xcarry_pkg;

  // Radix-2^51 limb geometry
  localparam int LIMB_W  = 51;
  localparam int LIMB_N  = 5;
  localparam int FOLD_K  = 19;
  localparam int TAG_W   = 5;

  // Datapath widths
  localparam int WORD_W  = 64;             // column words and output beats
  localparam int CARRY_W = 66;             // t and c inside the propagation step
  localparam int FOLD_W  = 72;             // u = limb0 + 19*c
  localparam int LIMBX_W = LIMB_W + 1;     // limb1 may reach 2^51 + 2^21 after the fold

  // Index helpers for the 3-bit column/beat counter
  localparam logic [2:0] LAST_COL  = 3'(LIMB_N - 1);
  localparam logic [2:0] LIMB_N_3  = 3'(LIMB_N);
`ifdef XCARRY_FOLD_EN
  localparam logic [2:0] LAST_BEAT = 3'(LIMB_N - 1);
`else
  localparam logic [2:0] LAST_BEAT = 3'(LIMB_N);   // extra beat carries c[63:0]
`endif

  // Controller states
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PROP = 2'd1,
    ST_FOLD = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  // Zero-extend a (possibly widened) limb into an output word
  function automatic logic [WORD_W-1:0] limb_to_word(input logic [LIMBX_W-1:0] limb);
    return WORD_W'(limb);
  endfunction

endpackage

// File: rtl/xcarry_step.sv
// One carry-propagation step: folds the incoming carry into a column's low
// word, keeps 51 bits as the limb and pushes the rest plus the high word
// forward as the next carry. Purely combinational; the top time-shares it.
module xcarry_step
  import xcarry_pkg::*;
(
  input  logic [WORD_W-1:0]  lo_i,
  input  logic [WORD_W-1:0]  hi_i,
  input  logic [CARRY_W-1:0] cin_i,
  output logic [LIMB_W-1:0]  limb_o,
  output logic [CARRY_W-1:0] cout_o
);

  logic [CARRY_W-1:0] t_w;

  // t = lo + c; limb = t mod 2^51; c' = hi + (t >> 51)
  always_comb begin
    t_w    = CARRY_W'(lo_i) + cin_i;
    limb_o = t_w[LIMB_W-1:0];
    cout_o = CARRY_W'(hi_i) + CARRY_W'(t_w[CARRY_W-1:LIMB_W]);
  end

endmodule

// File: rtl/xcarry.sv
// Column-to-limb carry reducer. Collects five (lo, hi) column beats, whose
// value is lo + hi*2^51, propagates carries into five 51-bit limbs, optionally
// folds the top carry back with 2^255 = 19 (mod p), then streams the limbs.
// Build option: XCARRY_FOLD_EN enables the fold; otherwise the carry-out is
// sent as a 6th beat (out_idx = 5) and the limbs are left unreduced.
//
// Handshake: a beat moves on a rising edge only when valid and ready are both
// high. in_ready is high exactly in LOAD; out_valid is high exactly in EMIT,
// and out_data/out_idx/out_tag are registers that change only on a transfer,
// so they hold while out_ready is low.
module xcarry
  import xcarry_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [WORD_W-1:0] in_lo,
  input  logic [WORD_W-1:0] in_hi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [2:0]        out_idx,
  output logic [TAG_W-1:0]  out_tag,
  output state_e            dbg_state
);

  // Controller state and counters
  state_e             state_q;
  logic [2:0]         cnt_q;          // column index in LOAD/PROP, beat index in EMIT
  logic [CARRY_W-1:0] c_q;            // running carry
  logic [TAG_W-1:0]   tag_q;

  // Column storage and reduced limbs
  logic [WORD_W-1:0]  col_lo_q [LIMB_N];
  logic [WORD_W-1:0]  col_hi_q [LIMB_N];
  logic [LIMBX_W-1:0] limb_q   [LIMB_N];

  // Registered output beat
  logic               out_valid_q;
  logic [WORD_W-1:0]  out_data_q;
  logic [2:0]         out_idx_q;

  // Shared step datapath
  logic [LIMB_W-1:0]  step_limb;
  logic [CARRY_W-1:0] step_cout;

  // Next-beat selection in EMIT
  logic [2:0]         next_k;
  logic [WORD_W-1:0]  emit_next;

  xcarry_step u_step (
    .lo_i   (col_lo_q[cnt_q]),
    .hi_i   (col_hi_q[cnt_q]),
    .cin_i  (c_q),
    .limb_o (step_limb),
    .cout_o (step_cout)
  );

`ifdef XCARRY_FOLD_EN
  logic [FOLD_W-1:0] fold_u;

  // u = limb0 + 19*c, the wrap-around of the carry out of limb 4
  always_comb begin
    fold_u = FOLD_W'(limb_q[0]) + FOLD_W'(c_q) * FOLD_W'(FOLD_K);
  end
`else
  // Carry is below 2^63 by contract; only its low word is ever emitted
  logic unused_c_top;
  assign unused_c_top = |c_q[CARRY_W-1:WORD_W];
`endif

  // Data for the beat following the current one
  always_comb begin
    next_k    = cnt_q + 3'd1;
    emit_next = '0;
    if (next_k < LIMB_N_3) emit_next = limb_to_word(limb_q[next_k]);
`ifndef XCARRY_FOLD_EN
    else emit_next = c_q[WORD_W-1:0];
`endif
  end

  // Controller: collect columns, propagate, fold, then stream limbs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      c_q         <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            col_lo_q[cnt_q] <= in_lo;
            col_hi_q[cnt_q] <= in_hi;
            if (cnt_q == 3'd0) tag_q <= in_tag;
            if (cnt_q == LAST_COL) begin
              cnt_q   <= '0;
              c_q     <= '0;
              state_q <= ST_PROP;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end

        ST_PROP: begin
          limb_q[cnt_q] <= LIMBX_W'(step_limb);
          c_q           <= step_cout;
          if (cnt_q == LAST_COL) begin
            cnt_q <= '0;
`ifdef XCARRY_FOLD_EN
            state_q <= ST_FOLD;
`else
            // limb 0 was written four cycles ago, so it can be presented now
            state_q     <= ST_EMIT;
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            out_data_q  <= limb_to_word(limb_q[0]);
`endif
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        ST_FOLD: begin
`ifdef XCARRY_FOLD_EN
          // Present the folded limb 0 directly; its register updates together
          limb_q[0]   <= LIMBX_W'(fold_u[LIMB_W-1:0]);
          limb_q[1]   <= limb_q[1] + LIMBX_W'(fold_u[FOLD_W-1:LIMB_W]);
          out_data_q  <= WORD_W'(fold_u[LIMB_W-1:0]);
          out_valid_q <= 1'b1;
          out_idx_q   <= '0;
          cnt_q       <= '0;
          state_q     <= ST_EMIT;
`else
          // Unreachable without the fold; recover to a clean start
          cnt_q   <= '0;
          state_q <= ST_LOAD;
`endif
        end

        ST_EMIT: begin
          if (out_ready) begin
            if (cnt_q == LAST_BEAT) begin
              out_valid_q <= 1'b0;
              cnt_q       <= '0;
              c_q         <= '0;
              state_q     <= ST_LOAD;
            end else begin
              cnt_q      <= next_k;
              out_idx_q  <= next_k;
              out_data_q <= emit_next;
            end
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_tag   = tag_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_xcarry.sv
// Directed bench for xcarry: hand-computed limb vectors, an expected-beat
// queue, input/output driver tasks and a single summary line.
module tb_xcarry;

`ifdef XCARRY_FOLD_EN
  localparam int N_BEATS = 5;
  localparam int LATENCY = 6;
`else
  localparam int N_BEATS = 6;
  localparam int LATENCY = 5;
`endif

  // Clock and reset
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [4:0]  in_tag    = '0;
  logic [63:0] in_lo     = '0;
  logic [63:0] in_hi     = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [2:0]  out_idx;
  logic [4:0]  out_tag;
  logic [1:0]  dbg_state;

  xcarry dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_lo     (in_lo),
    .in_hi     (in_hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_tag   (out_tag),
    .dbg_state (dbg_state)
  );

  // Scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] vec_lo[5];
  logic [63:0] vec_hi[5];

  localparam logic [63:0] P51    = 64'h0008_0000_0000_0000;
  localparam logic [63:0] M51    = 64'h0007_FFFF_FFFF_FFFF;
  localparam logic [63:0] M62    = 64'h3FFF_FFFF_FFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_vec();
    for (int b = 0; b < 5; b++) begin
      vec_lo[b] = '0;
      vec_hi[b] = '0;
    end
  endtask

  task automatic push_expect(input logic [63:0] l0, input logic [63:0] l1,
                             input logic [63:0] l2, input logic [63:0] l3,
                             input logic [63:0] l4, input logic [63:0] cfin);
    exp_q.push_back(l0);
    exp_q.push_back(l1);
    exp_q.push_back(l2);
    exp_q.push_back(l3);
    exp_q.push_back(l4);
    if (N_BEATS == 6) exp_q.push_back(cfin);
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,       64'd0);
    check("rst_out_idx",   64'(out_idx),   64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    reset = 1'b1;
  endtask

  // Input driver: five column beats; the tag differs after beat 0 so a late
  // capture shows up on out_tag
  task automatic send_op(input logic [4:0] tag);
    int guard;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_tag   = (b == 0) ? tag : ~tag;
      in_lo    = vec_lo[b];
      in_hi    = vec_hi[b];
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clock);
        #1;
        guard++;
      end
      check("in_ready_accept", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_lo    = '0;
    in_hi    = '0;
  endtask

  task automatic check_beat(input int k, input logic [63:0] e, input logic [4:0] tag);
    check("beat_valid", 64'(out_valid), 64'd1);
    check("beat_idx",   64'(out_idx),   64'(k));
    check("beat_data",  out_data,       e);
    check("beat_tag",   64'(out_tag),   64'(tag));
    check("beat_in_rdy",64'(in_ready),  64'd0);
  endtask

  // Output driver: latency check then every beat, optionally stalling one
  // cycle before each transfer
  task automatic collect(input logic [4:0] tag, input bit stall);
    int lat;
    logic [63:0] e;
    lat       = 0;
    out_ready = ~stall;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(LATENCY));
    for (int k = 0; k < N_BEATS; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
      if (stall) begin
        out_ready = 1'b0;
        check_beat(k, e, tag);
        @(posedge clock);
        #1;
      end
      out_ready = 1'b1;
      check_beat(k, e, tag);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b0;
    check("done_out_valid", 64'(out_valid), 64'd0);
    check("done_in_ready",  64'(in_ready),  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // All-zero columns
    clear_vec();
    send_op(5'd7);
    push_expect(0, 0, 0, 0, 0, 0);
    collect(5'd7, 1'b0);

    // col0.lo = 2^51 carries into limb 1
    clear_vec();
    vec_lo[0] = P51;
    send_op(5'd12);
    push_expect(0, 1, 0, 0, 0, 0);
    collect(5'd12, 1'b0);

    // col4.hi = 1 produces a top carry of 1
    clear_vec();
    vec_hi[4] = 64'd1;
    send_op(5'd21);
`ifdef XCARRY_FOLD_EN
    push_expect(19, 0, 0, 0, 0, 0);
`else
    push_expect(0, 0, 0, 0, 0, 1);
`endif
    collect(5'd21, 1'b0);

    // All lo = 2^51-1 with output stalls
    clear_vec();
    for (int b = 0; b < 5; b++) vec_lo[b] = M51;
    send_op(5'd3);
    push_expect(M51, M51, M51, M51, M51, 0);
    collect(5'd3, 1'b1);

    // Maximum legal words: lo = 2^51-1, hi = 2^62-1 everywhere
    for (int b = 0; b < 5; b++) begin
      vec_lo[b] = M51;
      vec_hi[b] = M62;
    end
    send_op(5'd31);
`ifdef XCARRY_FOLD_EN
    push_expect(64'h97FF, 64'h0008_0000_0000_97FF, 64'd2046, 64'd2047, 64'd2047, 0);
`else
    push_expect(M51, 64'h0007_FFFF_FFFF_FFFE, 64'd2046, 64'd2047, 64'd2047,
                64'h4000_0000_0000_0800);
`endif
    collect(5'd31, 1'b0);

    // Reset in PROP discards the operation in flight
    for (int b = 0; b < 5; b++) begin
      vec_lo[b] = 64'd123;
      vec_hi[b] = 64'd77;
    end
    send_op(5'd4);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_tag",   64'(out_tag),   64'd0);
    reset = 1'b1;
    clear_vec();
    vec_lo[2] = 64'd5;
    send_op(5'd9);
    push_expect(0, 0, 5, 0, 0, 0);
    collect(5'd9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xcarry.md
XCARRY -- requirements
Module: xcarry

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port `in_valid`, input, 1 bit: an input column beat is present.
REQ-004 SHALL have port `in_ready`, output, 1 bit: the block accepts a column beat.
REQ-005 SHALL have port `in_tag`, input, 5 bits: operation tag, sampled on the first beat only.
REQ-006 SHALL have port `in_lo`, input, 64 bits: accumulated MADDL column word.
REQ-007 SHALL have port `in_hi`, input, 64 bits: accumulated MADDH column word; column value = in_lo + in_hi·2^51.
REQ-008 SHALL have port `out_valid`, output, 1 bit: a reduced limb beat is present.
REQ-009 SHALL have port `out_ready`, input, 1 bit: the consumer accepts the beat.
REQ-010 SHALL have port `out_data`, output, 64 bits: reduced limb, zero-extended.
REQ-011 SHALL have port `out_idx`, output, 3 bits: limb index of `out_data`.
REQ-012 SHALL have port `out_tag`, output, 5 bits: tag captured on the first input beat.

Function
REQ-013 SHALL transfer a beat only when valid and ready are both high on the same rising edge.
REQ-014 SHALL use FSM states LOAD, PROP, FOLD and EMIT; reset state is LOAD.
REQ-015 In LOAD: in_ready=1; accept beats 0..4 into column registers col[0..4], counted by a 3-bit counter; the 5th accept moves the FSM to PROP with the counter cleared.
REQ-016 In PROP (one limb per cycle, i=0..4, carry c starting at 0): t=col[i].lo+c; limb[i]=t[50:0]; c=col[i].hi+(t>>51); after i=4 the FSM goes to FOLD.
REQ-017 In FOLD (1 cycle): u=limb[0]+19·c; limb[0]=u[50:0]; limb[1]+=u>>51; the FSM goes to EMIT.
REQ-018 In EMIT: out_valid=1 with out_idx=k and out_data=limb[k], k=0..4; k advances on each transfer; after the transfer at k=4 the FSM returns to LOAD.
REQ-019 in_ready SHALL be 0 in PROP, FOLD and EMIT; out_valid SHALL be 0 outside EMIT.
REQ-020 While out_ready=0 in EMIT, out_data, out_idx and out_tag SHALL hold stable.
REQ-021 Latency: first out_valid occurs 6 cycles after the 5th input transfer (5 PROP cycles + 1 FOLD cycle).
REQ-022 Width rules: t and c are 66 bits internally; u is 72 bits; output limb[0] and limb[2..4] are < 2^51; limb[1] is < 2^51+2^21.
REQ-023 Precondition: in_hi < 2^62; other values are outside the contract, and the bench SHALL NOT drive them.
REQ-024 A beat presented in PROP, FOLD or EMIT SHALL not be consumed; the upstream holds it until LOAD.

Reset
REQ-025 With reset=0 at a clock edge: FSM goes to LOAD; counters and carry are cleared; in_ready=1 next cycle; out_valid=0, out_data=0, out_idx=0, out_tag=0.
REQ-026 Reset mid-operation (any state) SHALL discard all partial columns and limbs; the next accepted beat is column 0.

Configuration
REQ-027 With macro XCARRY_FOLD_EN defined, FOLD SHALL operate as in REQ-017.
REQ-028 Without XCARRY_FOLD_EN: FOLD is skipped (PROP→EMIT, latency 5); EMIT gains a 6th beat with out_idx=5 and out_data=c[63:0]; limbs are not reduced mod 2^255-19.

Structure
REQ-029 A shared package SHALL hold: limb width 51, limb count 5, fold constant 19, tag width 5, and the FSM state encoding.
REQ-030 A single sub-module, xcarry_step (combinational: lo, hi, cin → limb, cout), SHALL be instantiated once and time-shared across PROP.

Verification
REQ-031 All lo=0, hi=0, tag=7 → limbs 0,0,0,0,0; out_tag=7; first out_valid 6 cycles after the last input.
REQ-032 col0.lo=2^51, all others 0 → limb0=0, limb1=1, limbs 2..4=0.
REQ-033 col4.hi=1, all others 0 → limb0=19, others 0 (FOLD_EN); without FOLD_EN, limbs all 0 and beat 5 = 1.
REQ-034 All lo=2^51-1, hi=0, out_ready toggling 1/0 each cycle → limbs 2^51-1 emitted in order 0..4, held stable while stalled, in_ready=0 throughout.
REQ-035 Reset asserted in PROP after 5 beats, then 5 new beats with col2.lo=5 → only new data appears: limb2=5, all others 0.
